// File: rtl/byte_sub_serial_if.sv
// Handshake and operand/result bundle for byte_sub_serial.
// The master side issues start with operands; the slave side returns busy/done and the result.
interface byte_sub_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             overflow;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout, overflow
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout, overflow
  );
endinterface

// File: rtl/byte_sub_serial.sv
// Bit-serial subtractor: Diff = A - B - Bin, LSB first, one full-subtractor cell per clock.
// Define BYTE_SUB_OVF_EN to register a signed overflow flag; otherwise overflow is tied low.
module byte_sub_serial #(
  parameter int WIDTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  byte_sub_serial_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sr, b_sr, res_q;
  logic             br_q, bout_q;
  logic             bit_a, bit_b, d, br_next;
  logic             last_bit, capture;

  // One full-subtractor cell working on the current LSBs.
  assign bit_a    = a_sr[0];
  assign bit_b    = b_sr[0];
  assign d        = bit_a ^ bit_b ^ br_q;
  assign br_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The result register is only touched on RUN edges, so Diff stays stable
  // from DONE until the next operation starts shifting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
      cnt_q  <= '0;
    end else if (capture) begin
      a_sr  <= bus.A;
      b_sr  <= bus.B;
      br_q  <= bus.Bin;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      res_q <= {d, res_q[WIDTH-1:1]};
      br_q  <= br_next;
      cnt_q <= cnt_q + CW'(1);
      if (last_bit) bout_q <= br_next;
    end
  end

`ifdef BYTE_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  // Operand sign bits are saved at capture because the shift registers have
  // moved them to bit 0 by the time the final result bit is produced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (capture) begin
      a_msb_q <= bus.A[WIDTH-1];
      b_msb_q <= bus.B[WIDTH-1];
    end else if (state_q == RUN && last_bit) begin
      ovf_q <= (a_msb_q ^ b_msb_q) & (d ^ a_msb_q);
    end
  end

  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.Diff = res_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_byte_sub_serial.sv
// Scoreboard bench for byte_sub_serial: stimulus pushes model results, a monitor
// pops and compares on every done pulse and checks busy/done timing each cycle.
module tb_byte_sub_serial;

  localparam int WIDTH = 8;

`ifdef BYTE_SUB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    int               due;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_due = 0;
  exp_t scb[$];
  exp_t got;
  logic busy_exp;

  byte_sub_serial_if #(.WIDTH(WIDTH)) bus ();

  byte_sub_serial #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin, input int due);
    exp_t m;
    int   ures, sa, sbv, sres;
    ures   = int'(a) - int'(b) - int'(bin);
    m.diff = ures[WIDTH-1:0];
    m.bout = (ures < 0);
    sa     = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
    sbv    = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
    sres   = sa - sbv - int'(bin);
    m.ovf  = OVF_EN && ((sres > (1 << (WIDTH - 1)) - 1) || (sres < -(1 << (WIDTH - 1))));
    m.due  = due;
    return m;
  endfunction

  // Called at #1 after a posedge; waits until the DUT can accept, then issues
  // for exactly one capture edge and scrambles the inputs afterwards.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    while (cyc < last_due) begin
      @(posedge clock); #1;
    end
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    last_due  = cyc + 1 + WIDTH;
    scb.push_back(model(a, b, bin, last_due));
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.A     = WIDTH'($urandom);
    bus.B     = WIDTH'($urandom);
    bus.Bin   = 1'($urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
    end
  endtask

  // Monitor: busy window and done pulse derived from the scoreboard head.
  always @(negedge clock) begin
    if (!reset) begin
      busy_exp = (scb.size() > 0) && (cyc >= scb[0].due - WIDTH) && (cyc < scb[0].due);
      check("busy", bus.busy, busy_exp);
      if (bus.done && bus.busy) check("busy_and_done", 1'b1, 1'b0);
      if (bus.done) begin
        if (scb.size() == 0) begin
          check("unexpected_done", bus.done, 1'b0);
        end else begin
          got = scb.pop_front();
          check("done_cycle", cyc, got.due);
          check("diff", bus.Diff, got.diff);
          check("bout", bus.Bout, got.bout);
          check("overflow", bus.overflow, got.ovf);
        end
      end else if (scb.size() > 0 && cyc >= scb[0].due) begin
        check("missing_done", bus.done, 1'b1);
        void'(scb.pop_front());
      end
    end
  end

  initial begin
    int wait_cycles;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;

    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_diff", bus.Diff, '0);
    check("rst_bout", bus.Bout, 1'b0);
    check("rst_ovf", bus.overflow, 1'b0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    idle(1);

    // Directed cases: basic, underflow, borrow-in, signed overflow.
    issue(8'h05, 8'h03, 1'b0);
    idle(WIDTH + 3);
    issue(8'h00, 8'h01, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1);
    issue(8'h80, 8'h01, 1'b0);
    // Back-to-back: second start lands on the DONE cycle of the first.
    issue(8'h10, 8'h08, 1'b0);
    issue(8'h7F, 8'hFF, 1'b1);

    // Start pulsed mid-run with different operands must be ignored.
    issue(8'h33, 8'h11, 1'b0);
    idle(3);
    bus.start = 1'b1;
    bus.A     = 8'hAA;
    bus.B     = 8'h55;
    @(posedge clock); #1;
    bus.start = 1'b0;
    idle(WIDTH + 2);

    // Asynchronous reset in the 4th RUN cycle with a partially built result.
    issue(8'hFF, 8'h00, 1'b0);
    idle(3);
    #2;
    reset = 1'b1;
    scb.delete();
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_diff", bus.Diff, '0);
    check("abort_bout", bus.Bout, 1'b0);
    check("abort_ovf", bus.overflow, 1'b0);
    @(posedge clock); #1;
    reset    = 1'b0;
    last_due = 0;
    idle(WIDTH + 2);
    issue(8'h2A, 8'h0A, 1'b0);

    // Randomized sweep with occasional idle gaps.
    for (int i = 0; i < 1000; i++) begin
      issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      if ($urandom_range(3) == 0) idle($urandom_range(WIDTH + 4));
    end

    wait_cycles = 0;
    while (scb.size() > 0 && wait_cycles < 4 * WIDTH) begin
      @(posedge clock); #1;
      wait_cycles++;
    end
    check("drain_timeout", scb.size(), 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
